// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, fetch FSM states and next-PC select encodings.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    DATA   = 2'b01,
    HALTED = 2'b10
  } fetch_state_t;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] PC_JR  = 2'b11;
endpackage

// File: rtl/next_pc.sv
// Combinational next-PC select: sequential, conditional branch, jump, jump-register.
module next_pc
  import cpu_types_pkg::*;
(
  input  word_t       pc_plus4,
  input  logic [1:0]  pc_src,
  input  logic        bra,
  input  logic        zero,
  input  logic [15:0] imm16,
  input  logic [25:0] jaddr,
  input  word_t       rs_data,
  output word_t       npc
);
  word_t br_off;
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    npc = pc_plus4;
    case (pc_src)
      PC_SEQ: npc = pc_plus4;
      // bra flips the sense of the zero flag: BEQ when 0, BNE when 1
      PC_BR:  if (zero ^ bra) npc = pc_plus4 + br_off;
      PC_JMP: npc = {pc_plus4[31:28], jaddr, 2'b00};
      PC_JR:  npc = {rs_data[31:2], 2'b00};
    endcase
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC and arbitrates instruction vs data memory requests.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  PC_src,
  input  logic        bra,
  input  logic        zero,
  input  logic [15:0] imm16,
  input  logic [25:0] jaddr,
  input  word_t       rs_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        mem_halt,
  input  logic        ihit,
  input  logic        dhit,
  output word_t       PC,
  output word_t       PC_plus4,
  output logic        iREN,
  output logic        dREN,
  output logic        dWEN,
  output logic        halt
);
  fetch_state_t state, next_state;
  logic         dren_q, dwen_q;
  logic         mem_op, go_data, pc_en;
  word_t        npc;

  assign PC_plus4 = PC + 32'd4;
  assign mem_op   = MemRead | MemWrite;
  assign go_data  = (state == FETCH) && ihit && !mem_halt && mem_op;
  assign pc_en    = ((state == FETCH) && ihit && !mem_halt && !mem_op) ||
                    ((state == DATA) && dhit);

  next_pc u_next_pc (
    .pc_plus4 (PC_plus4),
    .pc_src   (PC_src),
    .bra      (bra),
    .zero     (zero),
    .imm16    (imm16),
    .jaddr    (jaddr),
    .rs_data  (rs_data),
    .npc      (npc)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= FETCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:   if (ihit) begin
                 if (mem_halt)    next_state = HALTED;
                 else if (mem_op) next_state = DATA;
               end
      DATA:    if (dhit) next_state = FETCH;
      HALTED:  next_state = HALTED;
      default: next_state = FETCH;
    endcase
  end

  always_comb begin
    iREN = (state == FETCH);
    dREN = (state == DATA) && dren_q;
    dWEN = (state == DATA) && dwen_q;
    halt = (state == HALTED);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PC <= {PC_INIT[31:2], 2'b00};
    end else if (pc_en) begin
      PC <= npc;
    end
  end

  // A malformed decode with both read and write set is treated as a read
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dren_q <= 1'b0;
      dwen_q <= 1'b0;
    end else if (go_data) begin
      dren_q <= MemRead;
      dwen_q <= MemWrite & ~MemRead;
    end else if ((state == DATA) && dhit) begin
      dren_q <= 1'b0;
      dwen_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a behavioural model of its fetch rules.
module tb_fetch_unit;
  localparam logic [31:0] INIT = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  PC_src;
  logic        bra, zero;
  logic [15:0] imm16;
  logic [25:0] jaddr;
  logic [31:0] rs_data;
  logic        MemRead, MemWrite, mem_halt, ihit, dhit;
  logic [31:0] PC, PC_plus4;
  logic        iREN, dREN, dWEN, halt;

  int checks = 0;
  int errors = 0;

  // model: 0 = fetching, 1 = waiting on data memory, 2 = halted
  logic [31:0] m_pc;
  int          m_mode;
  logic        m_rd, m_wr;

  fetch_unit #(.PC_INIT(INIT)) dut (
    .CLK(CLK), .RST(RST), .PC_src(PC_src), .bra(bra), .zero(zero),
    .imm16(imm16), .jaddr(jaddr), .rs_data(rs_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .mem_halt(mem_halt),
    .ihit(ihit), .dhit(dhit), .PC(PC), .PC_plus4(PC_plus4),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .halt(halt)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] target(input logic [31:0] pc);
    logic [31:0] seq;
    logic [31:0] hi;
    int          off;
    seq = pc + 32'd4;
    off = int'($signed(imm16)) * 4;
    hi  = seq & 32'hF000_0000;
    case (PC_src)
      2'd0:    return seq;
      2'd1:    return ((zero != bra) ? seq + 32'(off) : seq);
      2'd2:    return hi + (32'(jaddr) * 4);
      default: return rs_data & 32'hFFFF_FFFC;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".PC"}, PC, m_pc);
    chk({tag, ".PC_plus4"}, PC_plus4, m_pc + 32'd4);
    chk({tag, ".iREN"}, 32'(iREN), 32'(m_mode == 0));
    chk({tag, ".dREN"}, 32'(dREN), 32'(m_mode == 1 && m_rd));
    chk({tag, ".dWEN"}, 32'(dWEN), 32'(m_mode == 1 && m_wr));
    chk({tag, ".halt"}, 32'(halt), 32'(m_mode == 2));
    chk({tag, ".excl"}, 32'((dREN & dWEN) | ((dREN | dWEN) & iREN)), 32'd0);
  endtask

  task automatic model_step();
    if (m_mode == 0 && ihit) begin
      if (mem_halt) m_mode = 2;
      else if (MemRead || MemWrite) begin
        m_mode = 1;
        m_rd   = MemRead;
        m_wr   = MemWrite && !MemRead;
      end else m_pc = target(m_pc);
    end else if (m_mode == 1 && dhit) begin
      m_pc   = target(m_pc);
      m_mode = 0;
      m_rd   = 1'b0;
      m_wr   = 1'b0;
    end
  endtask

  task automatic tick(input string tag);
    @(posedge CLK);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic ctl(input logic ih, input logic dh, input logic mr, input logic mw,
                     input logic mh, input logic [1:0] src);
    ihit = ih; dhit = dh; MemRead = mr; MemWrite = mw; mem_halt = mh; PC_src = src;
  endtask

  task automatic model_reset();
    m_pc = INIT; m_mode = 0; m_rd = 1'b0; m_wr = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    RST = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic jump_to(input logic [31:0] a);
    rs_data = a;
    ctl(1, 0, 0, 0, 0, 2'd3);
    tick("jr_setup");
    chk("jr_setup_pc", PC, a & 32'hFFFF_FFFC);
  endtask

  task automatic branch(input logic b, input logic z, input logic [31:0] exp, input string tag);
    jump_to(32'h40);
    bra = b; zero = z; imm16 = 16'hFFFE;
    ctl(1, 0, 0, 0, 0, 2'd1);
    tick(tag);
    chk(tag, PC, exp);
  endtask

  task automatic data_access(input logic rd, input string tag);
    jump_to(32'h20);
    ctl(1, 0, rd, !rd, 0, 2'd0);
    tick({tag, "_issue"});
    chk({tag, "_pc_hold"}, PC, 32'h20);
    chk({tag, "_req"}, {30'd0, dWEN, dREN}, rd ? 32'd1 : 32'd2);
    chk({tag, "_iren_off"}, 32'(iREN), 32'd0);
    for (int i = 0; i < 3; i++) begin
      ctl(i == 1, 0, rd, !rd, 0, 2'd0);
      tick({tag, "_wait"});
    end
    ctl(0, 1, rd, !rd, 0, 2'd0);
    tick({tag, "_done"});
    chk({tag, "_pc_adv"}, PC, 32'h24);
    chk({tag, "_iren_on"}, 32'(iREN), 32'd1);
  endtask

  initial begin
    RST = 1'b0; bra = 0; zero = 0; imm16 = '0; jaddr = '0; rs_data = '0;
    ctl(0, 0, 0, 0, 0, 2'd0);
    do_reset("reset");
    chk("reset_pc", PC, INIT);
    chk("reset_iren", 32'(iREN), 32'd1);

    // sequential fetch from reset
    ctl(1, 0, 0, 0, 0, 2'd0);
    for (int i = 1; i <= 3; i++) begin
      tick("seq");
      chk("seq_pc", PC, 32'(i * 4));
      chk("seq_iren", 32'(iREN), 32'd1);
    end
    ctl(0, 1, 0, 0, 0, 2'd1);
    tick("stall");
    chk("stall_pc", PC, 32'hC);

    branch(0, 1, 32'h3C, "beq_taken");
    branch(0, 0, 32'h44, "beq_not");
    branch(1, 0, 32'h3C, "bne_taken");

    jump_to(32'h1000_0000);
    jaddr = 26'h0000100;
    ctl(1, 0, 0, 0, 0, 2'd2);
    tick("jmp");
    chk("jmp_pc", PC, 32'h1000_0400);
    rs_data = 32'h0000_2003;
    ctl(1, 0, 0, 0, 0, 2'd3);
    tick("jr");
    chk("jr_pc", PC, 32'h0000_2000);

    // wrap at the top of the address space
    jump_to(32'hFFFF_FFFC);
    chk("wrap_plus4", PC_plus4, 32'h0);
    ctl(1, 0, 0, 0, 0, 2'd0);
    tick("wrap");
    chk("wrap_pc", PC, 32'h0);

    data_access(1'b1, "load");
    data_access(1'b0, "store");

    // halt is sticky until reset
    jump_to(32'h80);
    ctl(1, 1, 0, 0, 1, 2'd0);
    tick("halt");
    chk("halt_flag", 32'(halt), 32'd1);
    for (int i = 0; i < 10; i++) begin
      rs_data = $urandom;
      ctl($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0,
          $urandom_range(0, 1), 2'($urandom_range(0, 3)));
      tick("halted");
      chk("halted_pc", PC, 32'h80);
      chk("halted_req", {29'd0, iREN, dREN, dWEN}, 32'd0);
    end
    @(posedge CLK); #3;
    do_reset("halt_reset");
    chk("halt_clear", 32'(halt), 32'd0);
    chk("halt_reset_pc", PC, INIT);

    // asynchronous reset during a data access
    jump_to(32'h100);
    ctl(1, 0, 1, 0, 0, 2'd0);
    tick("async_issue");
    chk("async_dren", 32'(dREN), 32'd1);
    ctl(0, 0, 1, 0, 0, 2'd0);
    @(posedge CLK); model_step(); #3;
    RST = 1'b1;
    #1;
    chk("async_dren_drop", 32'(dREN), 32'd0);
    chk("async_pc", PC, INIT);
    chk("async_iren", 32'(iREN), 32'd1);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    ctl(1, 0, 0, 0, 0, 2'd0);
    tick("first_fetch");
    chk("first_fetch_pc", PC, INIT + 32'd4);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      int mop;
      if (m_mode == 2) do_reset("rand_reset");
      mop = $urandom_range(0, 5);
      bra = 1'($urandom); zero = 1'($urandom);
      imm16 = 16'($urandom); jaddr = 26'($urandom); rs_data = $urandom;
      ctl($urandom_range(0, 9) < 7, $urandom_range(0, 1), mop == 0, mop == 1,
          $urandom_range(0, 29) == 0, 2'($urandom_range(0, 3)));
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
